top_pc: RTL and testbench

Instruction-fetch front end: an 8-bit byte-addressed program counter, a +4 next-PC adder, a 64-word combinational instruction ROM and a field decoder. It sits at the head of the single-cycle datapath. It supplies the current instruction word and its register and immediate fields to the register file and ALU stages. The PC advances one word per clock and wraps modulo 256.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/instr_rom.sv | 19 +
 rtl/top_pc.sv | 49 ++++
 tb/tb_top_pc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the instruction-fetch front end: widths, PC step,
// boot program image and instruction field positions.
package pc_pkg;

   localparam int PC_W      = 8;
   localparam int INSTR_W   = 32;
   localparam int PC_STEP   = 4;
   localparam int ROM_DEPTH = 64;
   localparam int ROM_AW    = 6;

   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

   // Four-instruction boot program, every remaining word is a nop.
   localparam logic [INSTR_W-1:0] IMEM_INIT [0:ROM_DEPTH-1] = '{
      0:       32'h0050_0093,
      1:       32'h00A0_0113,
      2:       32'h0020_81B3,
      3:       32'h4011_8233,
      default: NOP_WORD
   };

   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;
   localparam int IMM_LSB = 20;
   localparam int IMM_MSB = 31;

endpackage

// File: rtl/instr_rom.sv
// Combinational read-only instruction memory holding the boot program image.
module instr_rom
   import pc_pkg::*;
#(
   parameter int DEPTH = ROM_DEPTH
) (
   input  logic [ROM_AW-1:0]  addr_i,
   output logic [INSTR_W-1:0] data_o
);

   // Any index beyond a shrunken depth still reads a harmless nop.
   always_comb begin
      data_o = NOP_WORD;
      if (int'(addr_i) < DEPTH) begin
         data_o = IMEM_INIT[addr_i];
      end
   end

endmodule

// File: rtl/top_pc.sv
// Fetch front end: byte-addressed PC register, +PC_STEP adder, instruction ROM
// lookup and raw field slicing of the fetched word.
module top_pc #(
   parameter int ROM_WORDS = pc_pkg::ROM_DEPTH,
   parameter int PC_STEP   = pc_pkg::PC_STEP
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  next,
   output logic [7:0]  current,
   output logic [31:0] out,
   output logic [4:0]  RD,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   output logic [11:0] IMM
);

   import pc_pkg::*;

   logic [PC_W-1:0] current_q;
   logic [PC_W-1:0] current_d;

   // Eight-bit sum truncates, so 0xFC rolls over to 0x00 with no carry kept.
   assign current_d = current_q + 8'(PC_STEP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         current_q <= '0;
      end else begin
         current_q <= current_d;
      end
   end

   assign current = current_q;
   assign next    = current_d;

   instr_rom #(
      .DEPTH (ROM_WORDS)
   ) u_instr_rom (
      .addr_i (current_q[PC_W-1:2]),
      .data_o (out)
   );

   assign RD  = out[RD_MSB:RD_LSB];
   assign RS1 = out[RS1_MSB:RS1_LSB];
   assign RS2 = out[RS2_MSB:RS2_LSB];
   assign IMM = out[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_top_pc.sv
// Self-checking bench for top_pc: reset values, fetch sequence, wrap and
// asynchronous reset, with a scoreboard of expected {current, out} pairs.
module tb_top_pc;

   logic        clk;
   logic        reset;
   logic [7:0]  next;
   logic [7:0]  current;
   logic [31:0] out;
   logic [4:0]  RD;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic [11:0] IMM;

   int checks;
   int errors;

   logic [39:0] exp_q[$];
   logic [7:0]  exp_pc;

   top_pc dut (
      .clk     (clk),
      .reset   (reset),
      .next    (next),
      .current (current),
      .out     (out),
      .RD      (RD),
      .RS1     (RS1),
      .RS2     (RS2),
      .IMM     (IMM)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Reference program image, written out independently of the package.
   function automatic logic [31:0] model_word(input logic [7:0] pc);
      logic [5:0] idx;
      idx = pc[7:2];
      case (idx)
         6'd0:    return 32'h00500093;
         6'd1:    return 32'h00A00113;
         6'd2:    return 32'h002081B3;
         6'd3:    return 32'h40118233;
         default: return 32'h00000013;
      endcase
   endfunction

   // Driver: hold reset low across two edges, release mid-cycle.
   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      exp_pc = 8'h00;
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (current !== 8'h00) begin errors++; $display("FAIL reset_async_current: got %h want 00", current); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (current !== 8'h00) begin errors++; $display("FAIL reset_current: got %h want 00", current); end
      checks++;
      if (next !== 8'h04) begin errors++; $display("FAIL reset_next: got %h want 04", next); end
      checks++;
      if (out !== 32'h00500093) begin errors++; $display("FAIL reset_out: got %h want 00500093", out); end
      checks++;
      if ({RD, RS1, RS2, IMM} !== {5'd1, 5'd0, 5'd5, 12'h005}) begin
         errors++;
         $display("FAIL reset_fields: got RD=%0d RS1=%0d RS2=%0d IMM=%h want 1 0 5 005", RD, RS1, RS2, IMM);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_pc = 8'h00;
   endtask

   task automatic test_release();
      logic [39:0] exp;
      logic [31:0] w;
      for (int i = 1; i <= 3; i++) begin
         exp_pc = exp_pc + 8'd4;
         exp_q.push_back({exp_pc, model_word(exp_pc)});
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         w = exp[31:0];
         checks++;
         if ({current, out} !== exp) begin
            errors++;
            $display("FAIL release_edge%0d: got pc=%h out=%h want pc=%h out=%h", i, current, out, exp[39:32], w);
         end
         if (i == 2) begin
            checks++;
            if (out !== 32'h002081B3 || RD !== 5'd3 || RS1 !== 5'd1 || RS2 !== 5'd2) begin
               errors++;
               $display("FAIL edge2_decode: got out=%h RD=%0d RS1=%0d RS2=%0d want 002081b3 3 1 2", out, RD, RS1, RS2);
            end
         end
      end
      checks++;
      if ({current, next, out} !== {8'h0C, 8'h10, 32'h40118233}) begin
         errors++;
         $display("FAIL edge3_pc: got cur=%h next=%h out=%h want 0c 10 40118233", current, next, out);
      end
      checks++;
      if ({RD, RS1, RS2, IMM} !== {5'd4, 5'd3, 5'd1, 12'h401}) begin
         errors++;
         $display("FAIL edge3_fields: got RD=%0d RS1=%0d RS2=%0d IMM=%h want 4 3 1 401", RD, RS1, RS2, IMM);
      end
   endtask

   task automatic test_run_21();
      logic [39:0] exp;
      logic [31:0] w;
      apply_reset();
      for (int i = 1; i <= 21; i++) begin
         exp_pc = exp_pc + 8'd4;
         exp_q.push_back({exp_pc, model_word(exp_pc)});
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         w = exp[31:0];
         checks++;
         if ({current, out, RD, RS1, RS2, IMM} !== {exp, w[11:7], w[19:15], w[24:20], w[31:20]}) begin
            errors++;
            $display("FAIL run21_edge%0d: got pc=%h out=%h want pc=%h out=%h", i, current, out, exp[39:32], w);
         end
      end
      checks++;
      if ({current, out, RD, IMM} !== {8'h54, 32'h00000013, 5'd0, 12'h000}) begin
         errors++;
         $display("FAIL run21_final: got cur=%h out=%h RD=%0d IMM=%h want 54 00000013 0 000", current, out, RD, IMM);
      end
   endtask

   task automatic test_wrap();
      logic [39:0] exp;
      apply_reset();
      for (int i = 1; i <= 64; i++) begin
         exp_pc = exp_pc + 8'd4;
         exp_q.push_back({exp_pc, model_word(exp_pc)});
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if ({current, out} !== exp || next !== exp[39:32] + 8'd4) begin
            errors++;
            $display("FAIL wrap_edge%0d: got pc=%h next=%h out=%h want pc=%h out=%h", i, current, next, out, exp[39:32], exp[31:0]);
         end
         if (i == 63) begin
            checks++;
            if ({current, next} !== {8'hFC, 8'h00}) begin
               errors++;
               $display("FAIL wrap_63: got cur=%h next=%h want fc 00", current, next);
            end
         end
      end
      checks++;
      if ({current, out} !== {8'h00, 32'h00500093}) begin
         errors++;
         $display("FAIL wrap_64: got cur=%h out=%h want 00 00500093", current, out);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (current !== 8'h20) begin errors++; $display("FAIL async_pre: got %h want 20", current); end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({current, out} !== {8'h00, 32'h00500093}) begin
         errors++;
         $display("FAIL async_immediate: got cur=%h out=%h want 00 00500093", current, out);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({current, next} !== {8'h00, 8'h04}) begin
            errors++;
            $display("FAIL async_hold%0d: got cur=%h next=%h want 00 04", i, current, next);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      exp_pc = 8'h00;
   endtask

   task automatic test_back_to_back();
      logic [39:0] exp;
      int n;
      apply_reset();
      n = $urandom_range(70, 140);
      for (int i = 1; i <= n; i++) begin
         exp_pc = exp_pc + 8'd4;
         exp_q.push_back({exp_pc, model_word(exp_pc)});
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if ({current, out} !== exp) begin
            errors++;
            $display("FAIL b2b_edge%0d: got pc=%h out=%h want pc=%h out=%h", i, current, out, exp[39:32], exp[31:0]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_pc = 8'h00;
      reset  = 1'b1;
      test_reset();
      test_release();
      test_run_21();
      test_wrap();
      test_async_reset();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
